// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Optional retired-instruction counter is built only when INSTR_CNT_EN is defined.
module mc_ctrl_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [2:0]  npc_op,
    output logic [1:0]  ext_op,
    output logic [1:0]  reg_dst,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [1:0]  mem_to_reg,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        I_NOP = 4'd0, I_ADD = 4'd1, I_SUB = 4'd2, I_JR  = 4'd3, I_ORI = 4'd4,
        I_LW  = 4'd5, I_SW  = 4'd6, I_BEQ = 4'd7, I_LUI = 4'd8, I_JAL = 4'd9
    } instr_t;

    state_t     state_q, state_d;
    instr_t     instr_s;
    logic [1:0] ex_alu_op_s;
    logic       ex_alu_src_s;
    logic [1:0] ex_ext_op_s;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction decode; unknown encodings collapse to nop
    always_comb begin
        instr_s = I_NOP;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: instr_s = I_ADD;
                    6'b100010: instr_s = I_SUB;
                    6'b001000: instr_s = I_JR;
                    default:   instr_s = I_NOP;
                endcase
            end
            6'b001101: instr_s = I_ORI;
            6'b100011: instr_s = I_LW;
            6'b101011: instr_s = I_SW;
            6'b000100: instr_s = I_BEQ;
            6'b001111: instr_s = I_LUI;
            6'b000011: instr_s = I_JAL;
            default:   instr_s = I_NOP;
        endcase
    end

    // ALU/extender selects set in EXEC and held through MEM and WB
    always_comb begin
        ex_alu_op_s  = 2'b00;
        ex_alu_src_s = 1'b0;
        ex_ext_op_s  = 2'b00;
        case (instr_s)
            I_SUB:       ex_alu_op_s = 2'b01;
            I_ORI:       begin ex_alu_op_s = 2'b10; ex_alu_src_s = 1'b1; end
            I_LUI:       begin ex_alu_op_s = 2'b10; ex_alu_src_s = 1'b1; ex_ext_op_s = 2'b10; end
            I_LW, I_SW:  begin ex_alu_src_s = 1'b1; ex_ext_op_s = 2'b01; end
            I_BEQ:       begin ex_alu_op_s = 2'b01; ex_ext_op_s = 2'b01; end
            default:     ex_alu_op_s = 2'b00;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (instr_s == I_NOP || instr_s == I_JR || instr_s == I_JAL) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (instr_s == I_LW || instr_s == I_SW) begin
                    state_d = S_MEM;
                end else if (instr_s == I_BEQ) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (!mem_ready) begin
                    state_d = S_MEM;
                end else if (instr_s == I_LW) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode; reset forces every control low even mid-transfer
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        reg_we       = 1'b0;
        npc_op       = 3'b000;
        ext_op       = 2'b00;
        reg_dst      = 2'b00;
        alu_src      = 1'b0;
        alu_op       = 2'b00;
        mem_to_reg   = 2'b00;
        if (!reset) begin
            mem_req = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                S_DECODE: begin
                    ext_op = ex_ext_op_s;
                    case (instr_s)
                        I_NOP:   pc_we = 1'b1;
                        I_JR:    begin pc_we = 1'b1; npc_op = 3'b011; end
                        I_JAL:   begin
                            pc_we      = 1'b1;
                            npc_op     = 3'b010;
                            reg_we     = 1'b1;
                            reg_dst    = 2'b10;
                            mem_to_reg = 2'b10;
                        end
                        default: pc_we = 1'b0;
                    endcase
                end
                S_EXEC: begin
                    ext_op  = ex_ext_op_s;
                    alu_op  = ex_alu_op_s;
                    alu_src = ex_alu_src_s;
                    if (instr_s == I_BEQ) begin
                        pc_we  = 1'b1;
                        npc_op = 3'b001;
                    end else begin
                        pc_we  = 1'b0;
                    end
                end
                S_MEM: begin
                    ext_op       = ex_ext_op_s;
                    alu_op       = ex_alu_op_s;
                    alu_src      = ex_alu_src_s;
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (instr_s == I_SW);
                    mdr_we       = mem_ready && (instr_s == I_LW);
                    pc_we        = mem_ready && (instr_s == I_SW);
                end
                S_WB: begin
                    ext_op     = ex_ext_op_s;
                    alu_op     = ex_alu_op_s;
                    alu_src    = ex_alu_src_s;
                    reg_we     = 1'b1;
                    pc_we      = 1'b1;
                    reg_dst    = (instr_s == I_ADD || instr_s == I_SUB) ? 2'b01 : 2'b00;
                    mem_to_reg = (instr_s == I_LW) ? 2'b01 : 2'b00;
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

`ifdef INSTR_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = pc_we ? (cnt_q + 32'd1) : cnt_q;

    // Retired-instruction counter, one tick per PC update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = 32'h0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: checks the full control vector every cycle of each instruction.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, reg_we;
    logic [2:0]  npc_op;
    logic [1:0]  ext_op, reg_dst, alu_op, mem_to_reg;
    logic        alu_src;
    logic [31:0] instr_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .mdr_we(mdr_we), .pc_we(pc_we), .reg_we(reg_we), .npc_op(npc_op), .ext_op(ext_op),
        .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Control vector: {req,we,asel,ir,mdr,pc,rw,npc[3],ext[2],dst[2],src,aop[2],m2r[2]}
    wire [18:0] ctl_s = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, reg_we,
                         npc_op, ext_op, reg_dst, alu_src, alu_op, mem_to_reg};

    function automatic logic [18:0] mk(input logic req, input logic we, input logic asel,
                                       input logic ir, input logic mdr, input logic pc,
                                       input logic rw, input logic [2:0] npc,
                                       input logic [1:0] ext, input logic [1:0] dst,
                                       input logic src, input logic [1:0] aop,
                                       input logic [1:0] m2r);
        return {req, we, asel, ir, mdr, pc, rw, npc, ext, dst, src, aop, m2r};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_expect();
`ifdef INSTR_CNT_EN
        return exp_cnt;
`else
        return 32'h0;
`endif
    endfunction

    // Called at a negedge: drive mem_ready, check, advance one full cycle
    task automatic step(input string tag, input logic rdy, input logic [18:0] exp);
        mem_ready = rdy;
        #1;
        check_val({tag, "/ctl"}, {13'd0, ctl_s}, {13'd0, exp});
        check_val({tag, "/cnt"}, instr_count, cnt_expect());
        @(negedge clk);
        if (exp[13]) exp_cnt++;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    logic [18:0] z, f_ok;

    initial begin
        z    = 19'd0;
        f_ok = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00);
        reset = 1'b0;
        mem_ready = 1'b1;
        set_instr(6'b000000, 6'b000000);
        repeat (3) @(negedge clk);
        step("rst_hold", 1'b1, z);
        reset = 1'b1;
        step("idle", 1'b1, z);

        // add: F D E W
        set_instr(6'b000000, 6'b100000);
        step("add_f", 1'b1, f_ok);
        step("add_d", 1'b1, z);
        step("add_e", 1'b1, z);
        step("add_w", 1'b1, mk(0,0,0,0,0,1,1,3'b000,2'b00,2'b01,0,2'b00,2'b00));

        // lw with two MEM wait cycles and one FETCH wait
        set_instr(6'b100011, 6'b000000);
        step("lw_fw", 1'b0, mk(1,0,0,0,0,0,0,3'b000,2'b00,2'b00,0,2'b00,2'b00));
        step("lw_f", 1'b1, f_ok);
        step("lw_d", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b01,2'b00,0,2'b00,2'b00));
        step("lw_e", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b01,2'b00,1,2'b00,2'b00));
        step("lw_m0", 1'b0, mk(1,0,1,0,0,0,0,3'b000,2'b01,2'b00,1,2'b00,2'b00));
        step("lw_m1", 1'b0, mk(1,0,1,0,0,0,0,3'b000,2'b01,2'b00,1,2'b00,2'b00));
        step("lw_m2", 1'b1, mk(1,0,1,0,1,0,0,3'b000,2'b01,2'b00,1,2'b00,2'b00));
        step("lw_w", 1'b1, mk(0,0,0,0,0,1,1,3'b000,2'b01,2'b00,1,2'b00,2'b01));

        // jal then jr
        set_instr(6'b000011, 6'b000000);
        step("jal_f", 1'b1, f_ok);
        step("jal_d", 1'b1, mk(0,0,0,0,0,1,1,3'b010,2'b00,2'b10,0,2'b00,2'b10));
        set_instr(6'b000000, 6'b001000);
        step("jr_f", 1'b1, f_ok);
        step("jr_d", 1'b1, mk(0,0,0,0,0,1,0,3'b011,2'b00,2'b00,0,2'b00,2'b00));

        // unknown opcode behaves as nop
        set_instr(6'b111111, 6'b101010);
        step("unk_f", 1'b1, f_ok);
        step("unk_d", 1'b1, mk(0,0,0,0,0,1,0,3'b000,2'b00,2'b00,0,2'b00,2'b00));

        // ori
        set_instr(6'b001101, 6'b000000);
        step("ori_f", 1'b1, f_ok);
        step("ori_d", 1'b1, z);
        step("ori_e", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b00,2'b00,1,2'b10,2'b00));
        step("ori_w", 1'b1, mk(0,0,0,0,0,1,1,3'b000,2'b00,2'b00,1,2'b10,2'b00));

        // lui
        set_instr(6'b001111, 6'b000000);
        step("lui_f", 1'b1, f_ok);
        step("lui_d", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b10,2'b00,0,2'b00,2'b00));
        step("lui_e", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b10,2'b00,1,2'b10,2'b00));
        step("lui_w", 1'b1, mk(0,0,0,0,0,1,1,3'b000,2'b10,2'b00,1,2'b10,2'b00));

        // sub
        set_instr(6'b000000, 6'b100010);
        step("sub_f", 1'b1, f_ok);
        step("sub_d", 1'b1, z);
        step("sub_e", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b00,2'b00,0,2'b01,2'b00));
        step("sub_w", 1'b1, mk(0,0,0,0,0,1,1,3'b000,2'b00,2'b01,0,2'b01,2'b00));

        // sw stalled in MEM, then reset pulsed mid-transfer
        set_instr(6'b101011, 6'b000000);
        step("swr_f", 1'b1, f_ok);
        step("swr_d", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b01,2'b00,0,2'b00,2'b00));
        step("swr_e", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b01,2'b00,1,2'b00,2'b00));
        mem_ready = 1'b0;
        #1;
        check_val("swr_m/ctl", {13'd0, ctl_s}, {13'd0, mk(1,1,1,0,0,0,0,3'b000,2'b01,2'b00,1,2'b00,2'b00)});
        #1;
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        check_val("swr_rst/ctl", {13'd0, ctl_s}, 32'd0);
        check_val("swr_rst/cnt", instr_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step("swr_idle", 1'b1, z);

        // beq, sw, add retire after reset
        set_instr(6'b000100, 6'b000000);
        step("beq_f", 1'b1, f_ok);
        step("beq_d", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b01,2'b00,0,2'b00,2'b00));
        step("beq_e", 1'b1, mk(0,0,0,0,0,1,0,3'b001,2'b01,2'b00,0,2'b01,2'b00));
        set_instr(6'b101011, 6'b000000);
        step("sw_f", 1'b1, f_ok);
        step("sw_d", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b01,2'b00,0,2'b00,2'b00));
        step("sw_e", 1'b1, mk(0,0,0,0,0,0,0,3'b000,2'b01,2'b00,1,2'b00,2'b00));
        step("sw_m", 1'b1, mk(1,1,1,0,0,1,0,3'b000,2'b01,2'b00,1,2'b00,2'b00));
        set_instr(6'b000000, 6'b100000);
        step("add2_f", 1'b1, f_ok);
        step("add2_d", 1'b1, z);
        step("add2_e", 1'b1, z);
        step("add2_w", 1'b1, mk(0,0,0,0,0,1,1,3'b000,2'b00,2'b01,0,2'b00,2'b00));
        set_instr(6'b000000, 6'b000000);
        step("final_f", 1'b1, f_ok);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control state machine for the MIPS datapath, with a single memory port shared by instruction fetch and lw/sw. It sequences one instruction at a time through FETCH/DECODE/EXEC/MEM/WB. Each state drives the datapath select signals already defined for the single-cycle controller (NPCOp, EXTOp, RegDst, ALUSrc, ALUOp, MemtoReg) plus the enables a multi-cycle datapath needs. The block sits between the IR and the datapath, and talks to memory through a req/ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces IDLE immediately.
- opcode  in  6  IR[31:26], stable from DECODE until the next FETCH.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR from memory read data.
- mdr_we  out  1  load MDR from memory read data.
- pc_we  out  1  PC <= NPC output.
- reg_we  out  1  GRF write enable.
- npc_op  out  3  000 PC+4, 001 beq, 010 jal, 011 jr.
- ext_op  out  2  00 zero, 01 sign, 10 lui.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- alu_src  out  1  0 = rt, 1 = ext imm.
- alu_op  out  2  00 add, 01 sub, 10 or.
- mem_to_reg  out  2  00 ALU, 01 MDR, 10 PC+4.
- instr_count  out  32  number of retired instructions (see Configuration).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. Outputs are a combinational Moore/Mealy decode of state, opcode and funct, plus mem_ready where noted. Every output not listed for a state is 0.
- Decoded instructions:
  - R-type (opcode 000000) with funct 100000 add, 100010 sub, 001000 jr, 000000 nop.
  - ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, jal 000011.
  - Any other encoding is treated as nop.
- IDLE: all outputs 0. Always moves to FETCH on the next edge.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - If mem_ready: ir_we=1, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - Drives ext_op for the decoded instruction.
  - nop/unknown: pc_we=1, npc_op=000, next state FETCH.
  - jr: pc_we=1, npc_op=011, next state FETCH.
  - jal: pc_we=1, npc_op=010, reg_we=1, reg_dst=10, mem_to_reg=10, next state FETCH. The NPC provides PC+4 before the PC updates.
  - All other instructions go to EXEC.
- EXEC:
  - add: alu_op=00, alu_src=0.
  - sub: alu_op=01, alu_src=0.
  - ori: alu_op=10, alu_src=1, ext_op=00.
  - lui: alu_op=10, alu_src=1, ext_op=10.
  - lw/sw: alu_op=00, alu_src=1, ext_op=01, next state MEM.
  - beq: alu_op=01, ext_op=01, pc_we=1, npc_op=001, next state FETCH. The NPC uses the ALU zero flag to choose the target.
  - R-type, ori and lui go to WB.
- MEM:
  - mem_req=1, mem_addr_sel=1; mem_we=1 for sw.
  - Select signals from EXEC are held.
  - On mem_ready: lw asserts mdr_we=1 and goes to WB. sw asserts pc_we=1, npc_op=000 and goes to FETCH.
- WB:
  - reg_we=1, pc_we=1, npc_op=000, next state FETCH.
  - reg_dst is 01 for R-type, 00 otherwise.
  - mem_to_reg is 01 for lw, 00 otherwise.
  - ALU/ext selects are held from EXEC.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay constant until the cycle in which mem_ready=1 is sampled.
  - The request completes on that edge. mem_req drops in the following cycle unless a new request begins.
  - mem_ready while mem_req=0 is ignored.
  - mem_ready held permanently high gives zero-wait operation.

## Timing
- Reset: asynchronous. Asserting reset moves state to IDLE, all outputs go to 0 combinationally (mem_req drops mid-transfer), and instr_count returns to 0. The first FETCH is the cycle after the first edge with reset=1.
- Cycles per instruction with zero-wait memory:
  - jr, jal, nop: 2.
  - beq: 3.
  - R-type, ori, lui, sw: 4.
  - lw: 5.
- Each memory wait cycle adds exactly 1 cycle to FETCH or MEM.
- pc_we is asserted exactly once per instruction, in its final state.
- reg_we is asserted for at most one cycle per instruction.

## Configuration
- INSTR_CNT_EN defined: instr_count increments by 1 on every edge where pc_we=1. It wraps from 0xFFFFFFFF to 0x00000000.
- INSTR_CNT_EN undefined: instr_count is tied to 32'h0 and no counter register is built.

## Test plan
- Reset held low, then released, mem_ready=1 -> outputs 0 in IDLE; next cycle mem_req=1, mem_addr_sel=0; ir_we=1 in that same cycle.
- add (op 000000, funct 100000), mem_ready=1 -> states F,D,E,W over 4 cycles. In WB: reg_we=1, reg_dst=01, alu_op=00, pc_we=1.
- lw with mem_ready low for 2 cycles in MEM -> mem_req=1, mem_addr_sel=1, mem_we=0 for 3 cycles, then mdr_we=1. WB follows with mem_to_reg=01. Total 7 cycles.
- jal then jr -> each takes 2 cycles. jal DECODE shows npc_op=010, reg_dst=10, mem_to_reg=10, reg_we=1. jr DECODE shows npc_op=011, reg_we=0.
- Opcode 111111 -> treated as nop: 2 cycles, pc_we=1, no reg_we or mem_we.
- reset pulsed low during sw MEM wait -> mem_req and mem_we drop in that cycle, then re-FETCH. With INSTR_CNT_EN, instr_count=0 after reset and reads 3 after beq, sw, add retire.
